uart_rx: RTL and testbench

UART receiver for the priRV32 core: the receiving end of the 8N1 serial link whose transmit side runs at the same CLK_MHZ/BAUD setting. It samples the asynchronous rxd line, reassembles bytes LSB-first, and presents each byte on a valid/ready handshake to the core or the debug path. Framing errors and overruns are flagged as one-cycle pulses.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: byte, valid/ready and error pulses.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, samples each bit at mid-bit, and hands
// bytes out through a one-entry holding register with valid/ready.
module uart_rx #(
    parameter int unsigned CLK_MHZ = 50,
    parameter int unsigned BAUD    = 115200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master bus
);
    localparam int unsigned DIV  = (CLK_MHZ * 1000000) / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;

    logic        s1_q, s1_d;
    logic        rs_q, rs_d;
    logic [2:0]  state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        s1_d    = rxd;
        rs_d    = s1_q;
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                if (rs_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rs_q) begin
                    div_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (div_q == HALF_M1) begin
                    div_d = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    if (rs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (div_q == DIV_M1) begin
                    div_d          = '0;
                    shift_d[idx_q] = rs_q;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (div_q == DIV_M1) begin
                    div_d = '0;
                    if (rs_q) begin
                        state_d = ST_IDLE;
                        // A drain in this same cycle frees the register for the new byte.
                        if (!valid_q || bus.rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            rs_q    <= 1'b1;
            state_q <= ST_WAIT_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            rs_q    <= rs_d;
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default settings (434 clocks per bit).
module tb_uart_rx;
    localparam int DIV = 434;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] got_q[$];
    int lat;
    int low_cnt;

    uart_rx_if bus ();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Observe mid-low-phase: inputs settled at negedge, outputs settled since posedge.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.frame_err === 1'b1) ferr_cnt++;
            if (bus.overrun === 1'b1) ovr_cnt++;
            if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) got_q.push_back(bus.rx_data);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on a negedge with the stop level still driven.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        rxd = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(DIV);
        end
        rxd = stop_lvl;
        wait_clks(DIV);
    endtask

    task automatic clear_log();
        got_q.delete();
        ferr_cnt = 0;
        ovr_cnt = 0;
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        wait_clks(3);
        chk1("rst_valid", bus.rx_valid, 1'b0);
        chk8("rst_data", bus.rx_data, 8'h00);
        chk1("rst_ferr", bus.frame_err, 1'b0);
        chk1("rst_ovr", bus.overrun, 1'b0);
        rst = 1'b0;
        wait_clks(10);

        // 1: latency and hold with rx_ready low
        clear_log();
        lat = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (bus.rx_valid !== 1'b1 && lat < 6000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        chk1("t1_latency", (lat >= 4123 && lat <= 4127), 1'b1);
        chk8("t1_data", bus.rx_data, 8'h55);
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h55) low_cnt++;
        end
        chkn("t1_hold", low_cnt, 0);

        // 2: back-to-back frames with rx_ready high
        bus.rx_ready = 1'b1;
        wait_clks(2);
        chk1("t1_drain", bus.rx_valid, 1'b0);
        clear_log();
        send_byte(8'hA3, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_clks(DIV);
        chkn("t2_count", got_q.size(), 3);
        chk8("t2_b0", got_q[0], 8'hA3);
        chk8("t2_b1", got_q[1], 8'h00);
        chk8("t2_b2", got_q[2], 8'hFF);
        chkn("t2_ferr", ferr_cnt, 0);
        chkn("t2_ovr", ovr_cnt, 0);

        // 3: short low glitch is ignored
        clear_log();
        rxd = 1'b0;
        wait_clks(100);
        rxd = 1'b1;
        wait_clks(2 * DIV);
        chkn("t3_nobyte", got_q.size(), 0);
        chkn("t3_noflags", ferr_cnt + ovr_cnt, 0);
        send_byte(8'h3C, 1'b1);
        wait_clks(10);
        chkn("t3_count", got_q.size(), 1);
        chk8("t3_data", got_q[0], 8'h3C);

        // 4: framing error, then a held-low line, then recovery
        clear_log();
        send_byte(8'h81, 1'b0);
        wait_clks(2000);
        chkn("t4_nobyte_low", got_q.size(), 0);
        rxd = 1'b1;
        wait_clks(DIV);
        send_byte(8'h42, 1'b1);
        wait_clks(10);
        chkn("t4_ferr", ferr_cnt, 1);
        chkn("t4_count", got_q.size(), 1);
        chk8("t4_data", got_q[0], 8'h42);

        // 5: overrun with rx_ready low, then drain coinciding with completion
        bus.rx_ready = 1'b0;
        wait_clks(1);
        clear_log();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_clks(10);
        chk8("t5_kept", bus.rx_data, 8'h11);
        chk1("t5_valid", bus.rx_valid, 1'b1);
        chkn("t5_ovr", ovr_cnt, 1);
        fork
            send_byte(8'h33, 1'b1);
            begin
                wait_clks(4125);
                bus.rx_ready = 1'b1;
                wait_clks(1);
                bus.rx_ready = 1'b0;
            end
        join
        chk1("t5_valid_swap", bus.rx_valid, 1'b1);
        chk8("t5_data_swap", bus.rx_data, 8'h33);
        chkn("t5_ovr_swap", ovr_cnt, 1);
        chkn("t5_drained", got_q.size(), 1);
        chk8("t5_drained_data", got_q[0], 8'h11);

        // 6: reset during bit 4 of a frame
        clear_log();
        fork
            send_byte(8'hF5, 1'b1);
            begin
                wait_clks(5 * DIV + DIV / 2);
                rst = 1'b1;
                wait_clks(1);
                rst = 1'b0;
                chk1("t6_rst_valid", bus.rx_valid, 1'b0);
                chk8("t6_rst_data", bus.rx_data, 8'h00);
            end
        join
        wait_clks(DIV);
        chk1("t6_nothing", bus.rx_valid, 1'b0);
        chkn("t6_noflags", ferr_cnt + ovr_cnt, 0);
        bus.rx_ready = 1'b1;
        send_byte(8'h7E, 1'b1);
        wait_clks(10);
        chkn("t6_count", got_q.size(), 1);
        chk8("t6_data", got_q[0], 8'h7E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
